npu_seq_ctrl: RTL and testbench

//  Parametrised host-command sequencer for the NPU datapath. It decodes host bus

---
 rtl/npu_seq_ctrl_if.sv | 12 +
 rtl/npu_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_npu_seq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/npu_seq_ctrl_if.sv
// Host register bus for the NPU sequencer: single-port enable/write strobe with a
// registered read-data return.
interface npu_seq_ctrl_if;
   logic        ena;
   logic        wea;
   logic [15:0] addra;
   logic [31:0] dina;
   logic [31:0] douta;

   modport master (output ena, wea, addra, dina, input douta);
   modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/npu_seq_ctrl.sv
// Host-command sequencer: conv1, CHAN accumulated conv2 passes, then the FC1 group
// stream to the final logit. Sticky status, IRQ, abort and progress/cycle counters.
module npu_seq_ctrl #(
   parameter int L1_PIXELS  = 182,
   parameter int L2_PIXELS  = 132,
   parameter int CHAN       = 10,
   parameter int FC1_GROUPS = 330,
   parameter int RES_W      = 24,
   parameter int PIX_W      = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   npu_seq_ctrl_if.slave    host,
   output logic             conv_trigger,
   output logic             conv_clear,
   output logic             conv_layer,
   output logic             psum_clear,
   input  logic [PIX_W-1:0] conv_pixel_addr,
   input  logic             conv_pixel_valid,
   output logic             fc_start,
   output logic             fc_next,
   input  logic             fc_valid,
   input  logic             fc_done,
   input  logic [RES_W-1:0] fc_logit,
   output logic             irq
);
   localparam int PW = $clog2(CHAN + 1);
   localparam int GW = $clog2(FC1_GROUPS + 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CONV1   = 3'd1;
   localparam logic [2:0] WAIT_W  = 3'd2;
   localparam logic [2:0] CONV2   = 3'd3;
   localparam logic [2:0] FC_WAIT = 3'd4;
   localparam logic [2:0] FC_RUN  = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [PW-1:0]    pass_cnt_q, pass_cnt_d, pass_inc;
   logic [GW-1:0]    grp_cnt_q, grp_cnt_d;
   logic [31:0]      cycle_cnt_q, cycle_cnt_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             done_q, done_d, err_q, err_d, irq_pend_q, irq_pend_d;
   logic             trig_q, trig_d, cclr_q, cclr_d, pclr_q, pclr_d;
   logic             layer_q, layer_d, fstart_q, fstart_d, fnext_q, fnext_d;
   logic [31:0]      douta_q, douta_d;

   logic [2:0]  sel;
   logic [11:0] idx;
   logic        cmd_wr, c_abort, c_start, c_wready, c_fnext, c_irqclr;
   logic        busy, last1, last2, got_done, set_err, set_done, clr_flags;
   logic        unused;

   assign sel      = host.addra[14:12];
   assign idx      = host.addra[11:0];
   assign cmd_wr   = host.ena && host.wea && (sel == 3'b101) && (idx == 12'd0);
   // Command bits are resolved to a single winner; IRQ_CLR rides alongside.
   assign c_abort  = cmd_wr && host.dina[1];
   assign c_start  = cmd_wr && host.dina[0] && !host.dina[1];
   assign c_wready = cmd_wr && host.dina[2] && (host.dina[1:0] == 2'b00);
   assign c_fnext  = cmd_wr && host.dina[3] && (host.dina[2:0] == 3'b000);
   assign c_irqclr = cmd_wr && host.dina[4];
   assign busy     = (state_q != IDLE);
   assign last1    = conv_pixel_valid && (conv_pixel_addr == PIX_W'(L1_PIXELS - 1));
   assign last2    = conv_pixel_valid && (conv_pixel_addr == PIX_W'(L2_PIXELS - 1));
   assign got_done = !c_abort && fc_done && (state_q == FC_WAIT || state_q == FC_RUN);
   assign pass_inc = pass_cnt_q + PW'(1);
   assign unused   = ^{host.addra[15], host.dina[31:5]};

   always_comb begin
      state_d     = state_q;
      pass_cnt_d  = pass_cnt_q;
      grp_cnt_d   = grp_cnt_q;
      cycle_cnt_d = (busy && cycle_cnt_q != 32'hFFFF_FFFF) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
      result_d    = got_done ? fc_logit : result_q;
      layer_d     = layer_q;
      trig_d      = 1'b0;
      cclr_d      = 1'b0;
      pclr_d      = 1'b0;
      fstart_d    = 1'b0;
      fnext_d     = 1'b0;
      set_err     = 1'b0;
      set_done    = got_done;
      clr_flags   = c_irqclr;
      if (c_abort) begin
         state_d     = IDLE;
         cclr_d      = 1'b1;
         pclr_d      = 1'b1;
         layer_d     = 1'b0;
         pass_cnt_d  = '0;
         grp_cnt_d   = '0;
         cycle_cnt_d = '0;
      end else begin
         if ((c_start && busy) || (c_wready && state_q != WAIT_W) ||
             (c_fnext && state_q != FC_WAIT))
            set_err = 1'b1;
         case (state_q)
            IDLE: if (c_start) begin
               clr_flags   = 1'b1;
               pass_cnt_d  = '0;
               grp_cnt_d   = '0;
               cycle_cnt_d = '0;
               layer_d     = 1'b0;
               trig_d      = 1'b1;
               state_d     = CONV1;
            end
            CONV1: if (last1) begin
               cclr_d     = 1'b1;
               pclr_d     = 1'b1;
               layer_d    = 1'b1;
               pass_cnt_d = '0;
               state_d    = WAIT_W;
            end
            WAIT_W: if (c_wready) begin
               trig_d  = 1'b1;
               state_d = CONV2;
            end
            CONV2: if (last2) begin
               cclr_d     = 1'b1;
               pass_cnt_d = pass_inc;
               if (pass_inc == PW'(CHAN)) begin
                  layer_d  = 1'b0;
                  fstart_d = 1'b1;
                  state_d  = FC_WAIT;
               end else begin
                  state_d = WAIT_W;
               end
            end
            FC_WAIT: if (got_done) begin
               state_d = DONE;
            end else if (c_fnext) begin
               // Host asked for more groups than the FC1 layer holds.
               if (grp_cnt_q == GW'(FC1_GROUPS)) begin
                  set_err = 1'b1;
                  state_d = IDLE;
               end else begin
                  fnext_d = 1'b1;
                  state_d = FC_RUN;
               end
            end
            FC_RUN: if (got_done) begin
               state_d = DONE;
            end else if (fc_valid) begin
               grp_cnt_d = grp_cnt_q + GW'(1);
               state_d   = FC_WAIT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      done_d     = set_done || (done_q && !clr_flags);
      irq_pend_d = set_done || (irq_pend_q && !clr_flags);
      err_d      = set_err  || (err_q && !clr_flags);
   end

   always_comb begin
      douta_d = douta_q;
      if (host.ena && !host.wea) begin
         douta_d = '0;
         if (sel == 3'b111) begin
            case (idx)
               12'd0:   douta_d = {21'd0, state_q, 4'd0, err_q, busy, irq_pend_q, done_q};
               12'd4:   douta_d = 32'($signed(result_q));
               12'd8:   douta_d = 32'(pass_cnt_q);
               12'd12:  douta_d = 32'(grp_cnt_q);
               12'd16:  douta_d = cycle_cnt_q;
               default: douta_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pass_cnt_q  <= '0;
         grp_cnt_q   <= '0;
         cycle_cnt_q <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         irq_pend_q  <= 1'b0;
         trig_q      <= 1'b0;
         cclr_q      <= 1'b0;
         pclr_q      <= 1'b0;
         layer_q     <= 1'b0;
         fstart_q    <= 1'b0;
         fnext_q     <= 1'b0;
         douta_q     <= '0;
      end else begin
         state_q     <= state_d;
         pass_cnt_q  <= pass_cnt_d;
         grp_cnt_q   <= grp_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         result_q    <= result_d;
         done_q      <= done_d;
         err_q       <= err_d;
         irq_pend_q  <= irq_pend_d;
         trig_q      <= trig_d;
         cclr_q      <= cclr_d;
         pclr_q      <= pclr_d;
         layer_q     <= layer_d;
         fstart_q    <= fstart_d;
         fnext_q     <= fnext_d;
         douta_q     <= douta_d;
      end
   end

   assign conv_trigger = trig_q;
   assign conv_clear   = cclr_q;
   assign psum_clear   = pclr_q;
   assign conv_layer   = layer_q;
   assign fc_start     = fstart_q;
   assign fc_next      = fnext_q;
   assign irq          = irq_pend_q;
   assign host.douta   = douta_q;
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl: register reads are checked by a scoreboard
// monitor one cycle after issue; pulses are counted on the falling edge.
module tb_npu_seq_ctrl;
   localparam logic [4:0]  C_START = 5'h01, C_ABORT = 5'h02, C_WREADY = 5'h04;
   localparam logic [4:0]  C_FNEXT = 5'h08, C_IRQCLR = 5'h10;
   localparam logic [15:0] A_STAT = 16'h7000, A_RES = 16'h7004, A_PASS = 16'h7008;
   localparam logic [15:0] A_GRP  = 16'h700C, A_CYC = 16'h7010;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        conv_trigger, conv_clear, conv_layer, psum_clear, fc_start, fc_next, irq;
   logic [7:0]  conv_pixel_addr = '0;
   logic        conv_pixel_valid = 1'b0, fc_valid = 1'b0, fc_done = 1'b0;
   logic [23:0] fc_logit = '0;
   logic        rd_issued;

   int errs = 0, checks = 0;
   int n_trig = 0, n_cclr = 0, n_pclr = 0, n_fstart = 0, n_fnext = 0;
   int b_trig, b_cclr, b_pclr, b_fstart, b_fnext;
   logic [31:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   npu_seq_ctrl_if hbus ();

   npu_seq_ctrl #(.L1_PIXELS(4), .L2_PIXELS(3), .CHAN(2), .FC1_GROUPS(4),
                  .RES_W(24), .PIX_W(8)) dut (
      .clk(clk), .rst_ni(rst_ni), .host(hbus.slave),
      .conv_trigger(conv_trigger), .conv_clear(conv_clear), .conv_layer(conv_layer),
      .psum_clear(psum_clear), .conv_pixel_addr(conv_pixel_addr),
      .conv_pixel_valid(conv_pixel_valid), .fc_start(fc_start), .fc_next(fc_next),
      .fc_valid(fc_valid), .fc_done(fc_done), .fc_logit(fc_logit), .irq(irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) rd_issued <= hbus.ena && !hbus.wea;

   always @(negedge clk) begin
      if (conv_trigger) n_trig++;
      if (conv_clear)   n_cclr++;
      if (psum_clear)   n_pclr++;
      if (fc_start)     n_fstart++;
      if (fc_next)      n_fnext++;
      if (rd_issued === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL rd_unexpected: got %h expected no read data", hbus.douta);
         end else begin
            chk(name_q.pop_front(), hbus.douta, exp_q.pop_front());
         end
      end
   end

   task automatic snap();
      b_trig = n_trig; b_cclr = n_cclr; b_pclr = n_pclr; b_fstart = n_fstart; b_fnext = n_fnext;
   endtask

   // All drive tasks start and end on a falling edge, one cycle per operation.
   task automatic cmd(input logic [4:0] b);
      hbus.ena = 1'b1; hbus.wea = 1'b1; hbus.addra = 16'h5000; hbus.dina = {27'd0, b};
      @(negedge clk);
      hbus.ena = 1'b0; hbus.wea = 1'b0; hbus.dina = '0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
      hbus.ena = 1'b1; hbus.wea = 1'b0; hbus.addra = a;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      hbus.ena = 1'b0;
   endtask

   task automatic pix(input int a);
      conv_pixel_valid = 1'b1; conv_pixel_addr = 8'(a);
      @(negedge clk);
      conv_pixel_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_to_fc();
      cmd(C_START);
      for (int i = 0; i < 4; i++) pix(i);
      repeat (2) begin
         cmd(C_WREADY);
         for (int i = 0; i < 3; i++) pix(i);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      hbus.ena = 1'b0; hbus.wea = 1'b0; hbus.addra = '0; hbus.dina = '0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", 32'({conv_trigger, conv_clear, conv_layer, psum_clear,
                               fc_start, fc_next, irq}), 32'd0);
      chk("rst_douta", hbus.douta, 32'd0);
      rst_ni = 1'b1;
      rd(A_STAT, 32'h0, "rst_status");
      rd(A_CYC, 32'h0, "rst_cycle");

      // Full run: conv1, two conv2 passes, one FC group, logit -5.
      tick(1);
      snap();
      cmd(C_START);
      tick(2);
      rd(A_CYC, 32'd2, "cyc_latency");
      tick(2);
      chk("cyc_hold", hbus.douta, 32'd2);
      for (int i = 0; i < 4; i++) pix(i);
      chk("layer_conv2", 32'(conv_layer), 32'd1);
      rd(A_STAT, 32'h204, "wait_w_status");
      cmd(C_WREADY);
      for (int i = 0; i < 3; i++) pix(i);
      rd(A_PASS, 32'd1, "pass1");
      cmd(C_WREADY);
      for (int i = 0; i < 3; i++) pix(i);
      chk("layer_fc", 32'(conv_layer), 32'd0);
      rd(A_PASS, 32'd2, "pass2");
      cmd(C_FNEXT);
      fc_valid = 1'b1; @(negedge clk); fc_valid = 1'b0;
      rd(A_GRP, 32'd1, "grp1");
      fc_logit = 24'hFFFFFB; fc_done = 1'b1; @(negedge clk); fc_done = 1'b0;
      rd(A_RES, 32'hFFFF_FFFB, "result_neg5");
      rd(A_STAT, 32'h3, "done_status");
      tick(1);
      chk("irq_done", 32'(irq), 32'd1);
      chk("n_trigger", 32'(n_trig - b_trig), 32'd3);
      chk("n_psum_clear", 32'(n_pclr - b_pclr), 32'd1);
      chk("n_conv_clear", 32'(n_cclr - b_cclr), 32'd3);
      chk("n_fc_start", 32'(n_fstart - b_fstart), 32'd1);
      chk("n_fc_next", 32'(n_fnext - b_fnext), 32'd1);

      // Illegal WREADY in IDLE, then IRQ_CLR.
      snap();
      cmd(C_WREADY);
      rd(A_STAT, 32'hB, "illegal_err");
      cmd(C_IRQCLR);
      rd(A_STAT, 32'h0, "irqclr_status");
      tick(1);
      chk("illegal_no_trig", 32'(n_trig - b_trig), 32'd0);

      // ABORT outranks START in the same write.
      snap();
      cmd(C_ABORT | C_START);
      tick(1);
      chk("prio_no_trig", 32'(n_trig - b_trig), 32'd0);
      chk("prio_psum", 32'(n_pclr - b_pclr), 32'd1);
      rd(A_STAT, 32'h0, "prio_status");

      // ABORT in CONV2 with pass_cnt=1, after an illegal START.
      cmd(C_START);
      for (int i = 0; i < 4; i++) pix(i);
      cmd(C_WREADY);
      for (int i = 0; i < 3; i++) pix(i);
      cmd(C_WREADY);
      cmd(C_START);
      rd(A_STAT, 32'h30C, "conv2_err_status");
      rd(A_PASS, 32'd1, "conv2_pass1");
      cmd(C_ABORT);
      chk("abort_pulses", 32'({conv_clear, psum_clear, conv_layer}), 32'b110);
      tick(1);
      chk("abort_pulse_end", 32'({conv_clear, psum_clear}), 32'b00);
      rd(A_PASS, 32'd0, "abort_pass");
      rd(A_STAT, 32'h8, "abort_status");
      rd(A_CYC, 32'd0, "abort_cycle");
      cmd(C_IRQCLR);

      // IRQ_CLR on the same cycle as fc_done: the set wins.
      run_to_fc();
      cmd(C_FNEXT);
      hbus.ena = 1'b1; hbus.wea = 1'b1; hbus.addra = 16'h5000; hbus.dina = {27'd0, C_IRQCLR};
      fc_logit = 24'd100; fc_done = 1'b1;
      @(negedge clk);
      hbus.ena = 1'b0; hbus.wea = 1'b0; hbus.dina = '0; fc_done = 1'b0;
      tick(1);
      chk("irq_set_wins", 32'(irq), 32'd1);
      rd(A_RES, 32'd100, "result_100");
      rd(A_STAT, 32'h3, "set_wins_status");

      // Async reset in FC_RUN.
      run_to_fc();
      cmd(C_FNEXT);
      rd(A_PASS, 32'd2, "fc_run_pass");
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_outputs", 32'({conv_trigger, conv_clear, conv_layer, psum_clear,
                                fc_start, fc_next, irq}), 32'd0);
      chk("arst_douta", hbus.douta, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      snap();
      tick(3);
      chk("arst_no_pulses", 32'((n_trig - b_trig) + (n_cclr - b_cclr) + (n_pclr - b_pclr) +
                                (n_fstart - b_fstart) + (n_fnext - b_fnext)), 32'd0);
      rd(A_STAT, 32'h0, "arst_status");
      rd(A_CYC, 32'h0, "arst_cycle");

      tick(2);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
